voice_scheduler: RTL and testbench

- Sits between song_reader_new and a bank of NUM_VOICES note players.
- Takes each new_note/note/duration/metadata record from the song reader and assigns it to a voice, allocating or stealing as needed.
- Times the song-level note duration in beats and returns the note_done pulse that advances the reader.
- Maintains an independent beat countdown per voice, so overlapping notes (chords) release on their own schedule.

---
 rtl/music_pkg.sv | 15 +
 rtl/voice_slot.sv | 46 ++++
 rtl/voice_scheduler.sv | 138 +++++++++++++
 tb/tb_voice_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared widths, metadata field positions and FSM state codes for the music player blocks.
package music_pkg;

    localparam int unsigned NOTE_W           = 6;
    localparam int unsigned DUR_W            = 6;
    localparam int unsigned META_OVERLAP_BIT = 0;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

endpackage

// File: rtl/voice_slot.sv
// One voice: held note code, remaining-beat counter and sounding flag.
module voice_slot
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              beat_en,
    input  logic              flush,
    input  logic [NOTE_W-1:0] load_note,
    input  logic [DUR_W-1:0]  load_dur,
    output logic [NOTE_W-1:0] note,
    output logic              active,
    output logic [DUR_W-1:0]  remaining
);

    logic [NOTE_W-1:0] note_q;
    logic [DUR_W-1:0]  cnt_q;
    logic              active_q;

    // Flush beats load beats decrement; the note code is kept after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (flush) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            note_q   <= load_note;
            cnt_q    <= load_dur;
            active_q <= 1'b1;
        end else if (beat_en && active_q && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == DUR_W'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

    assign note      = note_q;
    assign active    = active_q;
    assign remaining = cnt_q;

endmodule

// File: rtl/voice_scheduler.sv
// Assigns song-reader notes to voice slots, steals when full, and times song-level note length.
module voice_scheduler
    import music_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         beat,
    input  logic                         new_note,
    input  logic [NOTE_W-1:0]            note,
    input  logic [DUR_W-1:0]             duration,
    input  logic [2:0]                   metadata,
    input  logic                         song_done,
    output logic                         note_done,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         busy
);

    logic [1:0]        state_q, state_d;
    logic [NOTE_W-1:0] note_q;
    logic [DUR_W-1:0]  dur_q;
    logic              overlap_q;
    logic [DUR_W-1:0]  timer_q, timer_d;
    logic              tick;
    logic              do_load;
    logic [NUM_VOICES-1:0] alloc_onehot;
    logic [DUR_W-1:0]  remaining [NUM_VOICES];
    logic              unused_meta;

    assign unused_meta = ^metadata[2:1];
    assign tick        = beat & play;

    // Lowest free voice, else the voice closest to release (lowest index on ties).
    always_comb begin : alloc
        logic             found;
        int               sel;
        logic [DUR_W-1:0] best;
        found = 1'b0;
        sel   = 0;
        best  = remaining[0];
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (!found && !voice_active[i]) begin
                found = 1'b1;
                sel   = i;
            end
        end
        if (!found) begin
            for (int i = 1; i < int'(NUM_VOICES); i++) begin
                if (remaining[i] < best) begin
                    best = remaining[i];
                    sel  = i;
                end
            end
        end
        alloc_onehot = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            alloc_onehot[i] = (i == sel);
        end
    end

    assign do_load    = (state_q == StLoad) && (note_q != NOTE_REST) && (dur_q != '0) && !song_done;
    assign voice_load = do_load ? alloc_onehot : '0;
    assign note_done  = (state_q == StDone) && !song_done;
    assign busy       = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (song_done) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (new_note) begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    if ((dur_q == '0) || overlap_q) begin
                        state_d = StDone;
                    end else begin
                        timer_d = dur_q;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (tick && (timer_q != '0)) begin
                        timer_d = timer_q - 1'b1;
                        if (timer_q == DUR_W'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            note_q    <= '0;
            dur_q     <= '0;
            overlap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if ((state_q == StIdle) && new_note && !song_done) begin
                note_q    <= note;
                dur_q     <= duration;
                overlap_q <= metadata[META_OVERLAP_BIT];
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_VOICES); g++) begin : g_voice
        voice_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (voice_load[g]),
            .beat_en   (tick),
            .flush     (song_done),
            .load_note (note_q),
            .load_dur  (dur_q),
            .note      (voice_note[g*NOTE_W +: NOTE_W]),
            .active    (voice_active[g]),
            .remaining (remaining[g])
        );
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized scoreboard bench for voice_scheduler against a beat-counting reference model.
module tb_voice_scheduler;
    import music_pkg::*;

    localparam int NV = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 play, beat, new_note, song_done;
    logic [NOTE_W-1:0]    note;
    logic [DUR_W-1:0]     duration;
    logic [2:0]           metadata;
    logic                 note_done;
    logic [NV-1:0]        voice_load;
    logic [NV*NOTE_W-1:0] voice_note;
    logic [NV-1:0]        voice_active;
    logic                 busy;

    voice_scheduler #(.NUM_VOICES(NV)) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .beat         (beat),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .metadata     (metadata),
        .song_done    (song_done),
        .note_done    (note_done),
        .voice_load   (voice_load),
        .voice_note   (voice_note),
        .voice_active (voice_active),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int idx; int nt;} load_t;
    typedef struct {logic [NV-1:0] act; logic bsy;} snap_t;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;
    load_t load_q[$];
    int    done_q[$];
    snap_t snap_q[$];

    // Reference model: beats left per voice, plus song-level bookkeeping by cycle number.
    int rem[NV];
    int issue_cyc  = -10;
    int busy_until = -10;
    int load_cyc   = -1;
    int done_due   = -1;
    int song_left  = 0;
    bit timed      = 1'b0;
    int pend_note, pend_dur;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit b, input bit p, input bit sd, input bit nn,
                        input int n, input int d, input int m);
        int    k, ld;
        bit    tk;
        snap_t s;
        @(posedge clk);
        #1;
        cyc++;
        k = cyc;
        beat      = b;
        play      = p;
        song_done = sd;
        new_note  = nn;
        note      = NOTE_W'(n);
        duration  = DUR_W'(d);
        metadata  = 3'(m);
        if (nn && !sd && (k > busy_until)) begin
            issue_cyc = k;
            load_cyc  = k + 1;
            pend_note = n;
            pend_dur  = d;
            if (m[0] || (d == 0)) begin
                timed      = 1'b0;
                done_due   = k + 2;
                busy_until = k + 2;
            end else begin
                timed      = 1'b1;
                song_left  = d;
                done_due   = -1;
                busy_until = 1000000;
            end
        end
        for (int i = 0; i < NV; i++) s.act[i] = (rem[i] > 0);
        s.bsy = (k > issue_cyc) && (k <= busy_until);
        snap_q.push_back(s);
        tk = b && p;
        if (sd) begin
            for (int i = 0; i < NV; i++) rem[i] = 0;
            load_cyc = -1;
            done_due = -1;
            timed    = 1'b0;
            if (busy_until >= k) busy_until = k;
        end else begin
            if (done_due == k) done_q.push_back(k);
            ld = -1;
            if ((load_cyc == k) && (pend_note != 0) && (pend_dur != 0)) begin
                for (int i = 0; i < NV; i++) if (ld < 0 && rem[i] == 0) ld = i;
                if (ld < 0) begin
                    ld = 0;
                    for (int i = 1; i < NV; i++) if (rem[i] < rem[ld]) ld = i;
                end
                load_q.push_back('{k, ld, pend_note});
            end
            for (int i = 0; i < NV; i++) begin
                if (i == ld) rem[i] = pend_dur;
                else if (tk && rem[i] > 0) rem[i]--;
            end
            if (timed && (k >= issue_cyc + 2) && tk) begin
                song_left--;
                if (song_left == 0) begin
                    timed      = 1'b0;
                    done_due   = k + 1;
                    busy_until = k + 1;
                end
            end
        end
    endtask

    task automatic issue_when_idle(input int n, input int d, input int m, input bit b);
        int guard = 0;
        while ((cyc + 1 <= busy_until) && (guard < 200)) begin
            step(b, 1'b1, 1'b0, 1'b0, 0, 0, 0);
            guard++;
        end
        if (guard >= 200) begin
            failures++;
            $display("FAIL idle_timeout: got busy expected idle (cycle %0d)", cyc);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, n, d, m);
    endtask

    // Monitor: compares DUT outputs against queued expectations, away from the active edge.
    bit pend_nc = 1'b0;
    int nc_idx, nc_val;
    always @(negedge clk) begin
        if (mon_en) begin
            snap_t s;
            load_t e;
            int    dc;
            if (snap_q.size() == 0) begin
                failures++;
                $display("FAIL snapshot: got empty queue expected entry (cycle %0d)", cyc);
            end else begin
                s = snap_q.pop_front();
                check("voice_active", voice_active, s.act);
                check("busy", busy, s.bsy);
            end
            if (pend_nc) begin
                check("voice_note", voice_note[nc_idx*NOTE_W +: NOTE_W], nc_val);
                pend_nc = 1'b0;
            end
            while (load_q.size() > 0 && load_q[0].cyc < cyc) begin
                e = load_q.pop_front();
                check("load_missing", 0, 1 << e.idx);
            end
            if (voice_load != '0) begin
                if (load_q.size() == 0) begin
                    check("load_unexpected", voice_load, 0);
                end else begin
                    e = load_q.pop_front();
                    check("load_cycle", cyc, e.cyc);
                    check("load_onehot", voice_load, 1 << e.idx);
                    pend_nc = 1'b1;
                    nc_idx  = e.idx;
                    nc_val  = e.nt;
                end
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                dc = done_q.pop_front();
                check("note_done_missing", 0, dc);
            end
            if (note_done) begin
                if (done_q.size() == 0) begin
                    check("note_done_unexpected", 1, 0);
                end else begin
                    dc = done_q.pop_front();
                    check("note_done_cycle", cyc, dc);
                end
            end
        end
    end

    initial begin
        int n, d;
        for (int i = 0; i < NV; i++) rem[i] = 0;
        reset = 1'b0; play = 1'b0; beat = 1'b0; new_note = 1'b0; song_done = 1'b0;
        note = '0; duration = '0; metadata = '0;
        #12;
        check("rst_voice_active", voice_active, 0);
        check("rst_busy", busy, 0);
        check("rst_note_done", note_done, 0);
        check("rst_voice_load", voice_load, 0);
        check("rst_voice_note", voice_note, 0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Directed: single timed note, chord, steal, rest, zero duration, pause, flush.
        issue_when_idle(20, 3, 0, 1'b0);
        for (int i = 0; i < 8; i++) step(i % 2 == 0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        issue_when_idle(10, 5, 1, 1'b0);
        issue_when_idle(14, 2, 1, 1'b0);
        issue_when_idle(17, 2, 1, 1'b0);
        issue_when_idle(30, 6, 1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        issue_when_idle(0, 4, 0, 1'b1);
        issue_when_idle(12, 0, 0, 1'b1);
        issue_when_idle(25, 2, 0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(i % 2 == 0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        issue_when_idle(7, 9, 1, 1'b1);
        issue_when_idle(8, 9, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);

        // Random phase, including ignored strobes while busy and rare flushes.
        for (int c = 0; c < 3000; c++) begin
            n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 63));
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                 n, d, int'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        check("load_q_drained", load_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        // Asynchronous reset in the middle of a timed note.
        issue_when_idle(9, 6, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        check("pre_reset_busy", busy, 1);
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_voice_active", voice_active, 0);
        check("async_busy", busy, 0);
        check("async_note_done", note_done, 0);
        check("async_voice_load", voice_load, 0);
        check("async_voice_note", voice_note, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
